// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the asynchronous-memory initiator.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    localparam int unsigned DEF_ADDR_W  = 6;
    localparam int unsigned DEF_DATA_W  = 64;
    localparam int unsigned DEF_ACC_CYC = 2;
    localparam int unsigned CNT_W       = $clog2(16);

endpackage

// File: rtl/mem_ctrl.sv
// Single-request initiator for a 64x64 asynchronous memory: sequences Addr,
// MemRd/MemWr and the shared DataBus through SETUP/ACCESS/HOLD phases.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ACC_CYC = DEF_ACC_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              MemWr,
    output logic              MemRd,
    output logic [ADDR_W-1:0] Addr,
    inout  wire  [DATA_W-1:0] DataBus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_memwr;
    logic              r_memrd;
    logic              r_drive_en;
    logic              r_rsp_valid;

    logic              w_accept;
    logic              w_we_nxt;
    logic              w_capture;
    logic              w_memwr_nxt;
    logic              w_memrd_nxt;
    logic              w_drive_nxt;
    logic              w_rsp_nxt;

    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_we_nxt  = w_accept ? req_we : r_we;
    assign w_capture = (r_state == ACCESS) && (r_cnt == '0) && !r_we;

    // State and every externally visible strobe are registered so the
    // memory sees glitch-free controls; the comb blocks only compute next values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_memwr     <= 1'b0;
            r_memrd     <= 1'b0;
            r_drive_en  <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_memwr     <= w_memwr_nxt;
            r_memrd     <= w_memrd_nxt;
            r_drive_en  <= w_drive_nxt;
            r_rsp_valid <= w_rsp_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_capture) begin
                r_rdata <= DataBus;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
                w_cnt_nxt   = CNT_W'(ACC_CYC - 1);
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            HOLD: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_memwr_nxt = (w_state_nxt == ACCESS) && w_we_nxt;
        w_memrd_nxt = (w_state_nxt == ACCESS) && !w_we_nxt;
        w_drive_nxt = (w_state_nxt != IDLE) && w_we_nxt;
        w_rsp_nxt   = (w_state_nxt == HOLD);
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign MemWr     = r_memwr;
    assign MemRd     = r_memrd;
    assign Addr      = r_addr;
    assign DataBus   = r_drive_en ? r_wdata : 'z;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table, hand sequences and a random
// run scored against a plain array model of the memory contents.
module tb_mem_ctrl;

    localparam int ACC = 2;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        req_valid, req_we;
    logic [5:0]  req_addr;
    logic [63:0] req_wdata;
    logic        req_ready, rsp_valid, MemWr, MemRd;
    logic [63:0] rsp_rdata;
    logic [5:0]  Addr;
    wire  [63:0] DataBus;

    logic        req_valid2, req_we2;
    logic [5:0]  req_addr2;
    logic [63:0] req_wdata2;
    logic        req_ready2, rsp_valid2, MemWr2, MemRd2;
    logic [63:0] rsp_rdata2;
    logic [5:0]  Addr2;
    wire  [63:0] DataBus2;

    mem_ctrl #(.ADDR_W(6), .DATA_W(64), .ACC_CYC(ACC)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .MemWr(MemWr), .MemRd(MemRd), .Addr(Addr), .DataBus(DataBus)
    );

    mem_ctrl #(.ADDR_W(6), .DATA_W(64), .ACC_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
        .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
        .MemWr(MemWr2), .MemRd(MemRd2), .Addr(Addr2), .DataBus(DataBus2)
    );

    // Asynchronous memories: drive while read strobe is high, write at strobe end.
    logic [63:0] mem  [64] = '{default: '0};
    logic [63:0] mem2 [64] = '{0: 64'h5A5A_C3C3_0F0F_0001, default: '0};
    assign DataBus  = MemRd  ? mem[Addr]   : 'z;
    assign DataBus2 = MemRd2 ? mem2[Addr2] : 'z;
    always @(posedge clk) if (MemWr)  mem[Addr]   <= DataBus;
    always @(posedge clk) if (MemWr2) mem2[Addr2] <= DataBus2;

    logic [63:0] ref_mem [64] = '{default: '0};
    logic [63:0] exp_last_rd;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_rel(input string name, input logic [63:0] v);
        total++;
        if (!($isunknown(v) || v == '0)) begin
            bad++;
            $display("FAIL %s: bus value %h expected released", name, v);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ((MemWr && MemRd) || (MemWr2 && MemRd2)) begin
                bad++;
                $display("FAIL strobe_overlap: MemWr=%b MemRd=%b MemWr2=%b MemRd2=%b required no overlap",
                         MemWr, MemRd, MemWr2, MemRd2);
            end
        end
    end

    // Starts at a negedge in IDLE, ends at the negedge of the next IDLE cycle.
    task automatic run_txn(input logic we, input logic [5:0] addr, input logic [63:0] wdata,
                           input logic [63:0] exp_rd, input bit keep);
        bit in_acc;
        chk("ready_before", req_ready, 1'b1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        if (!keep) begin
            req_valid = 1'b0;
            req_we    = ~we;
            req_addr  = ~addr;
            req_wdata = {$urandom, $urandom};
        end
        for (int k = 1; k <= ACC + 2; k++) begin
            @(negedge clk);
            in_acc = (k >= 2) && (k <= ACC + 1);
            chk("memwr", MemWr, in_acc && we);
            chk("memrd", MemRd, in_acc && !we);
            chk("addr", Addr, addr);
            chk("ready_busy", req_ready, 1'b0);
            chk("rsp_valid", rsp_valid, k == ACC + 2);
            if (we) chk("bus_wdata", DataBus, wdata);
            else if (!in_acc) chk_rel("bus_rd_rel", DataBus);
            if (k == ACC + 2 && !we) chk("rdata_hold", rsp_rdata, exp_rd);
        end
        if (!we) exp_last_rd = exp_rd;
        @(negedge clk);
        chk("ready_after", req_ready, 1'b1);
        chk("rsp_after", rsp_valid, 1'b0);
        chk("strobes_idle", {MemWr, MemRd}, 2'b00);
        chk("addr_idle", Addr, addr);
        chk_rel("bus_idle", DataBus);
        chk("rdata_kept", rsp_rdata, exp_last_rd);
    endtask

    task automatic do_op(input logic we, input logic [5:0] addr, input logic [63:0] wdata, input bit keep);
        logic [63:0] e;
        e = ref_mem[addr];
        if (we) ref_mem[addr] = wdata;
        run_txn(we, addr, wdata, e, keep);
    endtask

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 6'h05, 64'hDEADBEEF_CAFEF00D, 64'h0};
        vecs[1] = '{1'b0, 6'h05, 64'h0,                 64'hDEADBEEF_CAFEF00D};
        vecs[2] = '{1'b1, 6'h3F, 64'h1,                 64'h0};
        vecs[3] = '{1'b0, 6'h3F, 64'h0,                 64'h1};
        vecs[4] = '{1'b1, 6'h00, 64'h01234567_89ABCDEF, 64'h0};
        vecs[5] = '{1'b0, 6'h00, 64'h0,                 64'h01234567_89ABCDEF};
        vecs[6] = '{1'b0, 6'h05, 64'h0,                 64'hDEADBEEF_CAFEF00D};
        vecs[7] = '{1'b1, 6'h05, 64'hFFFFFFFF_FFFFFFFF, 64'h0};
        vecs[8] = '{1'b0, 6'h05, 64'h0,                 64'hFFFFFFFF_FFFFFFFF};

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; req_wdata2 = '0;
        exp_last_rd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_memwr", MemWr, 1'b0);
        chk("rst_memrd", MemRd, 1'b0);
        chk("rst_addr", Addr, 6'h00);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rdata", rsp_rdata, 64'h0);
        chk_rel("rst_bus", DataBus);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].we) ref_mem[vecs[i].addr] = vecs[i].wdata;
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0);
        end
        chk("mem5_written", mem[5], 64'hFFFFFFFF_FFFFFFFF);

        // req_valid held high across alternating write/read of 0x3F
        for (int i = 0; i < 4; i++) begin
            do_op(i % 2 == 0, 6'h3F, 64'h1, 1'b1);
        end
        req_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [5:0] a;
            a = 6'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) a = 6'h3F;
            do_op(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("idle_ready", req_ready, 1'b1);
                chk("idle_rsp", rsp_valid, 1'b0);
            end
        end

        // reset during the write ACCESS phase: transaction must vanish
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h2A; req_wdata = 64'h11112222_33334444;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_memwr_before", MemWr, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_memwr_drop", MemWr, 1'b0);
        chk("mid_memrd", MemRd, 1'b0);
        chk_rel("mid_bus", DataBus);
        chk("mid_addr", Addr, 6'h00);
        chk("mid_rsp", rsp_valid, 1'b0);
        exp_last_rd = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_rsp", rsp_valid, 1'b0);
            chk("post_rst_memwr", MemWr, 1'b0);
        end
        chk("mid_mem_untouched", mem[6'h2A], ref_mem[6'h2A]);
        do_op(1'b0, 6'h2A, 64'h0, 1'b0);
        do_op(1'b1, 6'h2A, 64'h0BAD_F00D_1234_5678, 1'b0);
        do_op(1'b0, 6'h2A, 64'h0, 1'b0);

        // ACC_CYC=1 instance: read of address 0
        req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = 6'h00;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        @(negedge clk);
        chk("a1_setup_memrd", MemRd2, 1'b0);
        chk("a1_setup_ready", req_ready2, 1'b0);
        @(negedge clk);
        chk("a1_access_memrd", MemRd2, 1'b1);
        chk("a1_access_rsp", rsp_valid2, 1'b0);
        @(negedge clk);
        chk("a1_hold_memrd", MemRd2, 1'b0);
        chk("a1_hold_rsp", rsp_valid2, 1'b1);
        chk("a1_rdata", rsp_rdata2, 64'h5A5A_C3C3_0F0F_0001);
        @(negedge clk);
        chk("a1_idle_ready", req_ready2, 1'b1);
        chk("a1_idle_rsp", rsp_valid2, 1'b0);
        chk_rel("a1_bus", DataBus2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
